// File: rtl/md_issue_ctrl_pkg.sv
// Shared constants for the multiply/divide issue path: MDU op codes (also used
// by the unit itself), mfhi/mflo select codes, controller state encoding and
// default unit latencies.
package md_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        MF_NONE = 2'd0,
        MF_HI   = 2'd1,
        MF_LO   = 2'd2
    } mf_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // Ops that occupy the unit for a full multiply/divide schedule.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // Single-cycle HI/LO writes.
    function automatic logic is_mt_op(input logic [2:0] op);
        return (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_lat_counter.sv
// Shadow latency down-counter: loads the unit's occupancy on issue, counts
// down while running and flags the edge on which it reaches zero.
module md_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count: this edge takes the counter from 1 to 0.
    assign done = dec && (cnt == W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit. Issues one start
// pulse (or one mthi/mtlo write) per instruction, shadows the unit's busy
// window with a latency counter, stalls D for MD-class instructions and
// muxes HI/LO for mfhi/mflo.
// Optional build macro: MDCTL_CHECK_EN adds a sticky shadow/busy mismatch
// flag on chk_err; without it chk_err is tied low.
//
// state | meaning
// IDLE  | no multiply/divide in flight, new MD op may issue
// RUN   | unit busy with multiply/divide, counter running down
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        e_hold,
    input  logic [1:0]  e_mf_sel,
    input  logic        d_md_use,
    input  logic        int_req,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic        stall_d,
    output logic [31:0] mf_data,
    output logic        chk_err
);

    md_state_e  state;
    logic       issued;
    logic       is_md;
    logic       is_mt;
    logic       fire;
    logic       cnt_done;
    logic [3:0] lat_sel;

    assign is_md = is_md_op(e_op);
    assign is_mt = is_mt_op(e_op);

    // The issued flag blocks re-issue while E is frozen on the same instruction.
    assign fire      = (state == ST_IDLE) && !int_req && !issued && (is_md || is_mt);
    assign mdu_start = fire && is_md;
    assign mdu_op    = fire ? e_op : 3'(MDU_NONE);
    assign mdu_a     = e_a;
    assign mdu_b     = e_b;
    assign stall_d   = d_md_use && ((state == ST_RUN) || mdu_start);

    assign lat_sel = ((e_op == MDU_MULT) || (e_op == MDU_MULTU)) ? 4'(MUL_LAT) : 4'(DIV_LAT);

    md_lat_counter #(.W(4)) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (mdu_start),
        .load_val (lat_sel),
        .dec      (state == ST_RUN),
        .done     (cnt_done)
    );

    // Issue FSM and one-issue-per-instruction flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            issued <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (mdu_start) state <= ST_RUN;
                ST_RUN:  if (cnt_done)  state <= ST_IDLE;
            endcase
            issued <= e_hold && (issued || fire);
        end
    end

    // HI/LO read mux for mfhi/mflo.
    always_comb begin
        mf_data = '0;
        case (e_mf_sel)
            MF_HI:   mf_data = mdu_hi;
            MF_LO:   mf_data = mdu_lo;
            default: mf_data = '0;
        endcase
    end

`ifdef MDCTL_CHECK_EN
    logic chk_err_q;

    // Sticky flag when the shadow RUN window disagrees with the unit's busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_err_q <= 1'b0;
        end else if (mdu_busy != (state == ST_RUN)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_busy;
    assign unused_busy = mdu_busy;
    assign chk_err     = 1'b0;
`endif

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Initiator-side controller for the multiply/divide unit, in the E stage of the pipelined MIPS core. It turns E-stage MD-class operations into exactly one `mdu_start` pulse or one mthi/mtlo write, and keeps a shadow latency counter aligned with the unit's 5/10-cycle schedule. From that counter it generates the D-stage stall for any MD-class instruction and muxes HI/LO for mfhi/mflo. Interrupt requests cancel issue.

## Interface
- `MUL_LAT`, 5, multiply occupancy in cycles; must equal the unit's multiply latency.
- `DIV_LAT`, 10, divide occupancy in cycles; must equal the unit's divide latency.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `e_op` in 3: E-stage MD operation code (shared constants).
- `e_a`, `e_b` in 32 each: E-stage forwarded rs/rt values.
- `e_hold` in 1: E stage frozen this cycle; the same instruction remains in E next cycle.
- `e_mf_sel` in 2: 0 none, 1 mfhi, 2 mflo.
- `d_md_use` in 1: D-stage instruction is MD-class, including mfhi/mflo.
- `int_req` in 1: interrupt/exception taken this cycle.
- `mdu_busy` in 1: busy from the multiply/divide unit.
- `mdu_hi`, `mdu_lo` in 32 each: HI/LO from the unit.
- `mdu_start` out 1: start pulse to the unit.
- `mdu_op` out 3: op code to the unit.
- `mdu_a`, `mdu_b` out 32 each: operands to the unit.
- `stall_d` out 1: freeze D and bubble E.
- `mf_data` out 32: mfhi/mflo result.
- `chk_err` out 1: sticky shadow/busy mismatch flag (see Configuration).

## Operation
- States: IDLE, RUN. Counter `cnt` is 4 bits.
- `is_md = e_op` ∈ {MULT, MULTU, DIV, DIVU}. `is_mt = e_op` ∈ {MTHI, MTLO}.
- `fire = (state==IDLE) & !int_req & !issued & (is_md | is_mt)`.
- `mdu_start = fire & is_md`.
- `mdu_op = fire ? e_op : MDU_NONE`.
- `mdu_a` and `mdu_b` pass `e_a` and `e_b` through.
- On `mdu_start`: load `cnt` = MUL_LAT for mult/multu, or DIV_LAT for div/divu, and go to RUN.
- RUN: decrement `cnt` each edge. On the edge where `cnt` goes 1→0, return to IDLE.
- mthi/mtlo: single-cycle write with no state change.
- `issued` flag: set on `fire & e_hold`, cleared when `!e_hold`. This guarantees one issue per instruction.
- `stall_d = d_md_use & (state==RUN | mdu_start)`.
- `mf_data`: `mdu_hi` when sel=1, `mdu_lo` when sel=2, else 0. Always combinational.
- `int_req` in RUN: no effect on the counter. The unit completes the operation.
- `int_req` together with a candidate op: op dropped, `mdu_op` = MDU_NONE, no state change.
- Undefined `e_op` codes: treated as MDU_NONE.

## Timing
- Reset (asynchronous): state=IDLE, `cnt`=0, `issued`=0, `chk_err`=0.
- With `e_op`=NONE after reset, `mdu_start`=0, `mdu_op`=NONE and `stall_d`=0. `mdu_a`, `mdu_b` and `mf_data` follow their inputs.
- Multiply issued in cycle 0: RUN in cycles 1–5, IDLE in cycle 6.
  - `stall_d` can be high in cycles 0–5, i.e. 6 cycles.
  - HI/LO are valid from cycle 6, when the unit's busy has dropped.
- Divide issued in cycle 0: RUN in cycles 1–10. `stall_d` can be high for 11 cycles.
- RUN cycles match the unit's busy-high cycles exactly.
- Reset during RUN: immediate IDLE. The unit is reset by the same signal.

## Configuration
- `MDCTL_CHECK_EN` defined: each edge, if `mdu_busy != (state==RUN)`, `chk_err` is set and stays set until reset.
- Not defined: `chk_err` is tied to 0 and no comparison logic is built.

## Structure
- Shared constants file holds:
  - MDU op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - mf_sel codes.
  - State encodings.
  - Default latencies.
- The unit itself uses the same op constants.
- One natural sub-module: `md_lat_counter` (load/decrement/zero-detect).

## Test plan
- MULT in cycle 0 with `d_md_use`=1 held → `mdu_start` for 1 cycle, `stall_d` high 6 cycles, IDLE in cycle 6; mflo of 3×7 returns 21.
- DIV 100/7 → 11 stall cycles, then mfhi=2 and mflo=14; `chk_err` stays 0 with `MDCTL_CHECK_EN` defined.
- MULT with `e_hold`=1 for 3 cycles → exactly one `mdu_start`; `issued` cleared when hold releases.
- MULT with `int_req`=1 → `mdu_start`=0, `mdu_op`=NONE, state stays IDLE, `stall_d`=0.
- MTHI 0xDEADBEEF with no op in flight → `mdu_op`=MTHI for 1 cycle, no stall; next cycle mfhi=0xDEADBEEF.
- `reset` asserted at cycle 3 of a DIV → asynchronous IDLE, `stall_d`=0; a new MULT issues in the cycle after `reset` deasserts.
